// File: rtl/bs_mult_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial multiplier sequencer.
// The counter width and total cycle count depend on N and PLAT, so helpers compute them per instance.
package bs_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } bs_state_e;

  // Array-drive cycles in one operation: N feed, N flush, PLAT drain.
  function automatic int bs_total_cyc(input int n, input int plat);
    return 2 * n + plat;
  endfunction

  function automatic int bs_cnt_w(input int n, input int plat);
    return $clog2(2 * n + plat + 1);
  endfunction

  localparam int N_DEF     = 8;
  localparam int PLAT_DEF  = 1;
  localparam int TOTAL_CYC = bs_total_cyc(N_DEF, PLAT_DEF);
  localparam int CNT_W     = bs_cnt_w(N_DEF, PLAT_DEF);

endpackage

// File: rtl/bs_mult_ctrl_deser.sv
// bs_deser: LSB-first serial-to-parallel capture register with an enable window.
// The assembled word is published on the final capture so the previous result stays readable meanwhile.
module bs_deser #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_last,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_word
);

  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_shift;

  assign w_shift = {i_bit, r_shreg[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_shreg <= '0;
    end else if (i_en) begin
      r_shreg <= w_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (i_en && i_last) begin
      r_word <= w_shift;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/bs_mult_ctrl.sv
// bs_mult_ctrl: sequencer feeding a bit-serial multiplier array and assembling its 2N-bit product.
// Define BS_MULT_CTRL_SIGNED_EN for two's-complement operands (sign bits are replayed during FLUSH).
module bs_mult_ctrl
  import bs_mult_pkg::*;
#(
  parameter int N    = 8,
  parameter int PLAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           x_bit,
  output logic           y_bit,
  output logic           xy_bit,
  output logic           rin_tok,
  output logic           lastbit,
  input  logic           p_bit,
  output logic [2*N-1:0] product,
  output logic           done
);

  localparam int C_TOTAL = bs_total_cyc(N, PLAT);
  localparam int C_CNT_W = bs_cnt_w(N, PLAT);

  localparam logic [C_CNT_W-1:0] C_ONE       = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_FEED_END  = C_CNT_W'(N - 1);
  localparam logic [C_CNT_W-1:0] C_FLUSH_END = C_CNT_W'(2 * N - 1);
  localparam logic [C_CNT_W-1:0] C_LAST_CAP  = C_CNT_W'(C_TOTAL - 1);

  bs_state_e          r_state;
  bs_state_e          w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       w_a_nxt;
  logic [N-1:0]       w_b_nxt;
  logic               w_accept;

`ifdef BS_MULT_CTRL_SIGNED_EN
  logic               r_a_sign;
  logic               r_b_sign;
`endif

  logic w_x_nxt;
  logic w_y_nxt;
  logic w_tok_nxt;
  logic w_last_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  logic r_x;
  logic r_y;
  logic r_xy;
  logic r_tok;
  logic r_last;
  logic r_busy;
  logic r_done;

  logic w_active;
  logic w_cap_en;
  logic w_cap_last;

  // Next-state, counter and operand shifters
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_accept    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = FEED;
          w_cnt_nxt   = '0;
          w_a_nxt     = a_in;
          w_b_nxt     = b_in;
        end
      end
      FEED: begin
        w_cnt_nxt = r_cnt + C_ONE;
        w_a_nxt   = r_a >> 1;
        w_b_nxt   = r_b >> 1;
        if (r_cnt == C_FEED_END) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_cnt_nxt = r_cnt + C_ONE;
        if (r_cnt == C_FLUSH_END) begin
          w_state_nxt = (PLAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        w_cnt_nxt = r_cnt + C_ONE;
        if (r_cnt == C_LAST_CAP) begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the upcoming state so the array sees them in that state's cycle
  always_comb begin
    w_x_nxt = 1'b0;
    w_y_nxt = 1'b0;
    case (w_state_nxt)
      FEED: begin
        w_x_nxt = w_a_nxt[0];
        w_y_nxt = w_b_nxt[0];
      end
`ifdef BS_MULT_CTRL_SIGNED_EN
      FLUSH: begin
        w_x_nxt = r_a_sign;
        w_y_nxt = r_b_sign;
      end
`endif
      default: begin
        w_x_nxt = 1'b0;
        w_y_nxt = 1'b0;
      end
    endcase
    w_tok_nxt  = (w_state_nxt == FEED) && (w_cnt_nxt == '0);
    w_last_nxt = (w_state_nxt == FLUSH) && (w_cnt_nxt == C_FLUSH_END);
    w_busy_nxt = (w_state_nxt == FEED) || (w_state_nxt == FLUSH) || (w_state_nxt == DRAIN);
    w_done_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_y     <= 1'b0;
      r_xy    <= 1'b0;
      r_tok   <= 1'b0;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_xy    <= w_x_nxt & w_y_nxt;
      r_tok   <= w_tok_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_a <= w_a_nxt;
    r_b <= w_b_nxt;
  end

`ifdef BS_MULT_CTRL_SIGNED_EN
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_sign <= a_in[N-1];
      r_b_sign <= b_in[N-1];
    end
  end
`endif

  // Capture window: product bit k returns PLAT cycles after drive cycle k; cnt never passes the last capture
  assign w_active   = (r_state == FEED) || (r_state == FLUSH) || (r_state == DRAIN);
  assign w_cap_en   = w_active && (int'(r_cnt) >= PLAT);
  assign w_cap_last = (r_cnt == C_LAST_CAP);

  bs_deser #(
    .DATA_W(2 * N)
  ) u_deser (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (w_cap_en),
    .i_last (w_cap_last),
    .i_bit  (p_bit),
    .o_word (product)
  );

  assign busy    = r_busy;
  assign x_bit   = r_x;
  assign y_bit   = r_y;
  assign xy_bit  = r_xy;
  assign rin_tok = r_tok;
  assign lastbit = r_last;
  assign done    = r_done;

endmodule

// File: tb/tb_bs_mult_ctrl.sv
// Self-checking bench for bs_mult_ctrl with a behavioural bit-serial array and a cycle-level scoreboard.
module tb_bs_mult_ctrl;

  localparam int N   = 8;
  localparam int PLAT = 1;
  localparam int W   = 2 * N;
  localparam int LAT = 2 * N + PLAT + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         x_bit;
  logic         y_bit;
  logic         xy_bit;
  logic         rin_tok;
  logic         lastbit;
  logic         p_bit;
  logic [W-1:0] product;
  logic         done;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bs_mult_ctrl #(
    .N   (N),
    .PLAT(PLAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .x_bit  (x_bit),
    .y_bit  (y_bit),
    .xy_bit (xy_bit),
    .rin_tok(rin_tok),
    .lastbit(lastbit),
    .p_bit  (p_bit),
    .product(product),
    .done   (done)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'(a);
    sb = longint'(b);
`ifdef BS_MULT_CTRL_SIGNED_EN
    if (a[N-1]) sa = sa - (longint'(1) << N);
    if (b[N-1]) sb = sb - (longint'(1) << N);
`endif
    p = 64'(sa * sb);
    return p[W-1:0];
  endfunction

  // Array: from the token onwards, product bit k = bit k of (streamed x) * (streamed y), emitted PLAT cycles later
  initial begin : array_model
    int          j;
    int          k;
    logic [63:0] xs;
    logic [63:0] ys;
    logic [63:0] xv;
    logic [63:0] yv;
    logic [63:0] pv;
    j     = -1;
    xs    = '0;
    ys    = '0;
    p_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (rin_tok === 1'b1) j = 0;
      else if (j >= 0) j++;
      if (j > W + PLAT + 2) j = -1;
      p_bit = 1'b0;
      if (j >= 0) begin
        xs[j] = x_bit;
        ys[j] = y_bit;
        k = j - PLAT;
        if (k >= 0 && k < W) begin
          xv = '0;
          yv = '0;
          for (int i = 0; i <= k; i++) begin
            xv[i] = xs[i];
            yv[i] = ys[i];
          end
          pv    = xv * yv;
          p_bit = pv[k];
        end
      end
    end
  end

  // Scoreboard: tracks the one in-flight operation by cycle number and checks every output each cycle
  initial begin : monitor
    bit           inflight;
    int           t_s;
    int           t_done;
    int           k;
    logic [N-1:0] ma;
    logic [N-1:0] mb;
    logic [W-1:0] exp_p;
    logic [W-1:0] held;
    logic         e_x;
    logic         e_y;
    inflight = 1'b0;
    t_s      = 0;
    t_done   = 0;
    ma       = '0;
    mb       = '0;
    exp_p    = '0;
    held     = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        inflight = 1'b0;
        held     = '0;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_lastbit", lastbit, 1);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_tok", rin_tok, 0);
        chk_eq("rst_x", x_bit, 0);
        chk_eq("rst_y", y_bit, 0);
        chk_eq("rst_xy", xy_bit, 0);
        chk_eq("rst_product", product, 0);
      end else begin
        if (inflight && t_done == cyc - 1) inflight = 1'b0;
        if (start && !inflight) begin
          inflight = 1'b1;
          t_s      = cyc;
          t_done   = cyc + LAT - 1;
          ma       = a_in;
          mb       = b_in;
          exp_p    = ref_prod(a_in, b_in);
        end
        k   = cyc - t_s;
        e_x = 1'b0;
        e_y = 1'b0;
        if (inflight && k < N) begin
          e_x = ma[k];
          e_y = mb[k];
        end
`ifdef BS_MULT_CTRL_SIGNED_EN
        else if (inflight && k < W) begin
          e_x = ma[N-1];
          e_y = mb[N-1];
        end
`endif
        chk_eq("busy", busy, inflight && cyc != t_done);
        chk_eq("done", done, inflight && cyc == t_done);
        chk_eq("rin_tok", rin_tok, inflight && k == 0);
        chk_eq("lastbit", lastbit, inflight && k == W - 1);
        chk_eq("x_bit", x_bit, e_x);
        chk_eq("y_bit", y_bit, e_y);
        chk_eq("xy_bit", xy_bit, x_bit & y_bit);
        if (inflight && cyc == t_done) held = exp_p;
        chk_eq("product", product, held);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the DONE cycle so a following call is back-to-back
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask

  // Same as op, plus a stray start three cycles in that must be ignored
  task automatic op_mid(input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a_in  = ~a;
    b_in  = b ^ 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT - 4) @(negedge clk);
  endtask

  initial begin : driver
    int gap;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(8'd3, 8'd5);
    @(negedge clk);
    op(8'd255, 8'd255);
    @(negedge clk);
    op(8'd0, 8'd200);
    op(8'd7, 8'd9);
    @(negedge clk);
    op_mid(8'd11, 8'd13);
    @(negedge clk);

    start = 1'b1;
    a_in  = 8'd77;
    b_in  = 8'd99;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op(8'd2, 8'd2);
    @(negedge clk);

    op(8'hFD, 8'd5);
    @(negedge clk);
    op(8'h80, 8'h80);
    @(negedge clk);

    repeat (30) begin
      if ($urandom_range(0, 3) == 0) op_mid(N'($urandom), N'($urandom));
      else op(N'($urandom), N'($urandom));
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
